cpu_step_ctrl: RTL
==================

# cpu_step_ctrl

Execution-rate controller directly upstream of the single-cycle CPU core. It replaces the raw divided clock with a one-cycle clock-enable pulse, `cpuEnOut`, that gates every state element of the core (PC, register file, data memory). The enable comes from one of three sources:
- a free-running rate divider;
- a debounced single-step button;
- a PC breakpoint halt.

It also keeps an executed-instruction counter for the display path.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable samples needed before the button level is accepted (10 ms at 100 MHz).
- `CNT_W`, default 16: width of the step counter.
- `clkIn` in 1: the single clock. All logic is on its rising edge.
- `resetIn` in 1: reset, synchronous and active-high.
- `stepBtnIn` in 1: raw, asynchronous step push-button.
- `runModeIn` in 1: 1 = free-run, 0 = halt/step (slide switch).
- `rateSelIn` in 2: free-run rate select.
- `bkptEnIn` in 1: enables the breakpoint compare.
- `bkptAddrIn` in 32: breakpoint byte address.
- `pcAddrIn` in 32: current PC from the core.
- `cpuEnOut` out 1: one-cycle enable pulse; the core advances one instruction per pulse.
- `haltedOut` out 1: 1 in HALT or BRK.
- `brkHitOut` out 1: 1 while in BRK.
- `stepCountOut` out CNT_W: number of enable pulses issued.

## Operation
**Button conditioning**
- `stepBtnIn` passes through a 2-flop synchronizer.
- A debounce counter accepts a new level after DEBOUNCE_CYCLES consecutive equal samples.
- A rising edge of the accepted level produces `stepPulse` for 1 cycle.

**Divider**
- 25-bit counter, cleared on entry to RUN, free-running otherwise.
- `tick` depends on `rateSelIn`:
  - 0: `tick` every cycle.
  - 1: when div[15:0] is all ones.
  - 2: when div[19:0] is all ones.
  - 3: when div[24:0] is all ones.

**FSM states** HALT, RUN, BRK.
- HALT:
  - `runModeIn`=1 → RUN and set `skipBkpt`.
  - `stepPulse` → issue one enable, stay in HALT.
- RUN:
  - `runModeIn`=0 → HALT; no enable is issued in that cycle.
  - Otherwise, on `tick`:
    - if breakpoint match and `!skipBkpt` → BRK, no enable;
    - else issue enable and clear `skipBkpt`.
- BRK:
  - `stepPulse` → issue one enable, stay in BRK.
  - `runModeIn`=0 → HALT.
  - To resume free-run, the switch must cycle through 0 (HALT→RUN sets `skipBkpt`).
- Breakpoint match is `bkptEnIn && pcAddrIn == bkptAddrIn`. It halts before the matching instruction executes.

**Other rules**
- `stepPulse` in RUN is ignored.
- If the `runModeIn` change and `tick` occur in the same cycle, the mode change wins.
- `stepCountOut` increments on every issued enable and wraps from all-ones to 0.

**Reset** (overrides everything)
- State HALT, `cpuEnOut`=0, `haltedOut`=1, `brkHitOut`=0, `stepCountOut`=0.
- Divider, debounce counter, synchronizer and `skipBkpt` all cleared.
- Reset mid-debounce discards the pending edge.

## Timing
- `cpuEnOut`, `haltedOut`, `brkHitOut` and `stepCountOut` are all registered.
- `cpuEnOut` rises the cycle after the qualifying tick or step, and lasts exactly 1 cycle.
- `stepCountOut` updates in the same cycle as `cpuEnOut` (it counts the pulse being shown).
- Button latency from a stable `stepBtnIn` to `cpuEnOut` = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Breakpoint compare uses `pcAddrIn` in the tick cycle. The PC is stable because it only changes on an enable.
- The HALT/BRK decision from `runModeIn` is visible on `haltedOut` 1 cycle after the switch is sampled.

## Configuration
- `STEP_CTRL_BKPT_EN` defined: breakpoint compare, BRK state, `skipBkpt` and `brkHitOut` logic are compiled in.
- Undefined:
  - `bkptEnIn` and `bkptAddrIn` are unused;
  - BRK is unreachable;
  - `brkHitOut` is tied to 0.

## Structure
- Shared package holds:
  - the state enum (HALT/RUN/BRK);
  - the divider width (25) and the tap constants for rate selects 1–3.
- One sub-module, `btn_debounce`: synchronizer, debounce counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset → `haltedOut`=1, `cpuEnOut`=0, `stepCountOut`=0. After release with no input, no enable for 100 cycles.
- Clean button press held 10 cycles in HALT → exactly one `cpuEnOut` pulse, 7 cycles after the press; `stepCountOut`=1.
- Button bouncing 0/1 every cycle for 3 cycles then held → a single pulse. A glitch shorter than 4 cycles → no pulse.
- `runModeIn`=1, `rateSelIn`=0 for 20 cycles → 20 consecutive pulses. Switching to 0 → pulses stop the next cycle and `haltedOut`=1.
- `bkptEnIn`=1, `bkptAddrIn`=0x0C, `pcAddrIn` model advancing by 4 per pulse from 0 → 3 pulses, then BRK with `brkHitOut`=1. A step then gives 1 pulse. Run 0→1 gives a pulse at the first tick despite the match.
- `stepCountOut` preset near wrap (CNT_W=4, 16 pulses) → reads 0 after the 16th pulse; a reset mid-RUN clears it and returns to HALT.

Source files
------------

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and constants for the CPU execution-rate controller.
// Breakpoint support in the top level is enabled with `define STEP_CTRL_BKPT_EN.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_BRK  = 2'd2
  } stepState_t;

  localparam int DIV_W     = 25;
  localparam int TAP_RATE1 = 16;
  localparam int TAP_RATE2 = 20;
  localparam int TAP_RATE3 = 25;

  // Rate 0 ticks every cycle; the others tick when the low TAP bits are all ones.
  function automatic logic divTick(input logic [DIV_W-1:0] div, input logic [1:0] rateSel);
    logic t;
    case (rateSel)
      2'd0:    t = 1'b1;
      2'd1:    t = &div[TAP_RATE1-1:0];
      2'd2:    t = &div[TAP_RATE2-1:0];
      default: t = &div[TAP_RATE3-1:0];
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Step-button conditioning: 2-flop synchronizer, level debounce and a
// one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clkIn,
  input  logic resetIn,
  input  logic btnIn,
  output logic pulseOut
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stableD;
  logic [CNT_W-1:0] cnt;

  // The counter tracks how many consecutive samples disagree with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      stableD <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btnIn;
      sync2   <= sync1;
      stableD <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulseOut = stable & ~stableD;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the single-cycle core: free-run divider,
// debounced single step and optional PC breakpoint (`define STEP_CTRL_BKPT_EN).
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 16
) (
  input  logic             clkIn,
  input  logic             resetIn,
  input  logic             stepBtnIn,
  input  logic             runModeIn,
  input  logic [1:0]       rateSelIn,
  input  logic             bkptEnIn,
  input  logic [31:0]      bkptAddrIn,
  input  logic [31:0]      pcAddrIn,
  output logic             cpuEnOut,
  output logic             haltedOut,
  output logic             brkHitOut,
  output logic [CNT_W-1:0] stepCountOut
);

  stepState_t       state;
  stepState_t       stateNext;
  logic [DIV_W-1:0] div;
  logic             stepPulse;
  logic             tick;
  logic             enNext;
  logic             enterRun;
  logic             bkptMatch;
  logic             skipBkpt;
  logic             skipNext;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebounce (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .btnIn   (stepBtnIn),
    .pulseOut(stepPulse)
  );

  assign tick = divTick(div, rateSelIn);

`ifdef STEP_CTRL_BKPT_EN
  assign bkptMatch = bkptEnIn && (pcAddrIn == bkptAddrIn);

  // skipBkpt lets the first tick after a resume execute the instruction we stopped on.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      skipBkpt  <= 1'b0;
      brkHitOut <= 1'b0;
    end else begin
      skipBkpt  <= skipNext;
      brkHitOut <= (stateNext == ST_BRK);
    end
  end
`else
  logic unusedBkpt;
  assign unusedBkpt = ^{bkptEnIn, bkptAddrIn, pcAddrIn, skipNext};
  assign bkptMatch  = 1'b0;
  assign skipBkpt   = 1'b0;
  assign brkHitOut  = 1'b0;
`endif

  // A runModeIn change always takes priority over a tick or a step in the same cycle.
  always_comb begin
    stateNext = state;
    enNext    = 1'b0;
    enterRun  = 1'b0;
    skipNext  = skipBkpt;
    case (state)
      ST_HALT: begin
        if (runModeIn) begin
          stateNext = ST_RUN;
          enterRun  = 1'b1;
          skipNext  = 1'b1;
        end else if (stepPulse) begin
          enNext = 1'b1;
        end
      end
      ST_RUN: begin
        if (!runModeIn) begin
          stateNext = ST_HALT;
        end else if (tick) begin
          if (bkptMatch && !skipBkpt) begin
            stateNext = ST_BRK;
          end else begin
            enNext   = 1'b1;
            skipNext = 1'b0;
          end
        end
      end
      ST_BRK: begin
        if (!runModeIn) begin
          stateNext = ST_HALT;
        end else if (stepPulse) begin
          enNext = 1'b1;
        end
      end
      default: stateNext = ST_HALT;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state        <= ST_HALT;
      div          <= '0;
      cpuEnOut     <= 1'b0;
      haltedOut    <= 1'b1;
      stepCountOut <= '0;
    end else begin
      state     <= stateNext;
      div       <= enterRun ? '0 : div + 1'b1;
      cpuEnOut  <= enNext;
      haltedOut <= (stateNext != ST_RUN);
      if (enNext) begin
        stepCountOut <= stepCountOut + 1'b1;
      end
    end
  end

endmodule
